// File: rtl/wb_collector_pkg.sv
// -----------------------------------------------------------------------------
// wb_collector_pkg
// Shared definitions for the writeback collector: packet field offsets and
// widths, the unpacked packet struct and small helpers that slice a raw
// 74-bit packet into its fields.
// Packet layout: {data[73:10], rd_idx[9:5], itag[4:0]}
// -----------------------------------------------------------------------------
package wb_collector_pkg;

  localparam int WB_DATA_MSB = 73;
  localparam int WB_DATA_LSB = 10;
  localparam int WB_RD_MSB   = 9;
  localparam int WB_RD_LSB   = 5;
  localparam int WB_TAG_MSB  = 4;
  localparam int WB_TAG_LSB  = 0;

  localparam int WB_PKT_W    = 74;
  localparam int TAG_W       = 5;
  localparam int REG_IDX_W   = 5;
  localparam int WB_DATA_W   = WB_DATA_MSB - WB_DATA_LSB + 1;

  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [REG_IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0]     itag;
  } wb_pkt_t;

  // Slice a raw packet by the documented offsets.
  function automatic wb_pkt_t unpack_pkt(input logic [WB_PKT_W-1:0] raw);
    wb_pkt_t p;
    p.data   = raw[WB_DATA_MSB:WB_DATA_LSB];
    p.rd_idx = raw[WB_RD_MSB:WB_RD_LSB];
    p.itag   = raw[WB_TAG_MSB:WB_TAG_LSB];
    return p;
  endfunction

  // x0 is hard-wired zero: the tag completes but the register file is untouched.
  function automatic logic writes_rf(input wb_pkt_t p);
    return p.rd_idx != '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Parameterised synchronous FIFO with occupancy count and full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push on a full FIFO is accepted only if a pop happens in the same cycle.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   push, din     enqueue request and data
//   pop, dout     dequeue request, head data (combinational read)
//   count         current occupancy (0..DEPTH)
//   full, empty   status flags
// -----------------------------------------------------------------------------
module wb_fifo
  import wb_collector_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = WB_PKT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers define
  // which entries are valid, so resetting it would only cost a reset net.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/wb_collector.sv
// -----------------------------------------------------------------------------
// wb_collector
// Serialises ALU results (no backpressure, buffered in wb_fifo) and slow-unit
// results (valid/ready) onto one register-file write port plus the itag
// completion broadcast. The slow unit wins when the FIFO is empty or after it
// has been denied STARVE_MAX consecutive cycles.
// Optional build macro WB_BYPASS_EN: an ALU result arriving at an empty FIFO
// while the slow unit is not granted goes straight to the output registers.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   alu_rd_en, alu_data         ALU result pulse and packet
//   su_valid, su_ready, su_data slow-unit handshake and packet
//   wb_valid, wb_we, wb_rd,
//   wb_wdata, wb_itag           registered writeback / completion
//   fifo_cnt                    ALU FIFO occupancy
//   ovf                         sticky ALU FIFO overflow (cleared by reset)
// -----------------------------------------------------------------------------
module wb_collector
  import wb_collector_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3,
  parameter int XLEN       = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_rd_en,
  input  logic [WB_PKT_W-1:0]    alu_data,
  input  logic                   su_valid,
  output logic                   su_ready,
  input  logic [WB_PKT_W-1:0]    su_data,
  output logic                   wb_valid,
  output logic                   wb_we,
  output logic [REG_IDX_W-1:0]   wb_rd,
  output logic [XLEN-1:0]        wb_wdata,
  output logic [TAG_W-1:0]       wb_itag,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   ovf
);

  localparam int                  STARVE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

  wb_pkt_t               alu_pkt;
  wb_pkt_t               su_pkt;
  wb_pkt_t               head_pkt;
  wb_pkt_t               sel_pkt;
  logic [WB_PKT_W-1:0]   head_raw;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  su_grant;
  logic                  bypass;
  logic                  load;
  logic                  drop;
  logic [STARVE_W-1:0]   starve_q;

  logic                  wb_valid_q;
  logic                  wb_we_q;
  logic [REG_IDX_W-1:0]  wb_rd_q;
  logic [XLEN-1:0]       wb_wdata_q;
  logic [TAG_W-1:0]      wb_itag_q;
  logic                  ovf_q;

  assign alu_pkt  = unpack_pkt(alu_data);
  assign su_pkt   = unpack_pkt(su_data);
  assign head_pkt = unpack_pkt(head_raw);

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (WB_PKT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (alu_data),
    .dout  (head_raw),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Arbitration. Gated by rst_n so a pending slow-unit request is never
  // acknowledged while reset is asserted.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    su_grant = 1'b0;
    fifo_pop = 1'b0;
    bypass   = 1'b0;
    load     = 1'b0;
    sel_pkt  = alu_pkt;
    if (rst_n) begin
      su_grant = su_valid && (fifo_empty || starve_q >= STARVE_LIM);
      fifo_pop = !su_grant && !fifo_empty;
`ifdef WB_BYPASS_EN
      bypass   = alu_rd_en && fifo_empty && !su_grant;
`endif
      load     = su_grant || fifo_pop || bypass;
      sel_pkt  = su_grant ? su_pkt : (fifo_pop ? head_pkt : alu_pkt);
    end
  end

  assign fifo_push = alu_rd_en && !bypass;
  // A push on a full FIFO survives only when the head leaves the same cycle.
  assign drop      = fifo_push && fifo_full && !fifo_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_wdata_q <= '0;
      wb_itag_q  <= '0;
    end else begin
      wb_valid_q <= load;
      wb_we_q    <= load && writes_rf(sel_pkt);
      // Payload holds its previous value on idle cycles.
      if (load) begin
        wb_rd_q    <= sel_pkt.rd_idx;
        wb_wdata_q <= sel_pkt.data;
        wb_itag_q  <= sel_pkt.itag;
      end
    end
  end

  // Counts consecutive cycles the slow unit waits; saturates at the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (!su_valid || su_grant) begin
      starve_q <= '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_q <= starve_q + STARVE_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  assign su_ready = su_grant;
  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_rd    = wb_rd_q;
  assign wb_wdata = wb_wdata_q;
  assign wb_itag  = wb_itag_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_wb_collector.sv
// -----------------------------------------------------------------------------
// tb_wb_collector
// Self-checking bench for wb_collector. A behavioural reference model decides
// each cycle which packet should be written back; the expectation is pushed
// onto a scoreboard queue when stimulus is driven and popped when the DUT
// output is sampled one clock later. Scenario tasks add targeted checks.
// -----------------------------------------------------------------------------
module tb_wb_collector;
  import wb_collector_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;
  localparam int XLEN       = 64;
  localparam int CNT_W      = $clog2(DEPTH) + 1;
`ifdef WB_BYPASS_EN
  localparam bit BYPASS     = 1'b1;
`else
  localparam bit BYPASS     = 1'b0;
`endif
  localparam int EXP_LAT    = BYPASS ? 1 : 2;
  localparam wb_pkt_t NO_PKT = '0;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 alu_rd_en;
  logic [WB_PKT_W-1:0]  alu_data;
  logic                 su_valid;
  logic                 su_ready;
  logic [WB_PKT_W-1:0]  su_data;
  logic                 wb_valid;
  logic                 wb_we;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [XLEN-1:0]      wb_wdata;
  logic [TAG_W-1:0]     wb_itag;
  logic [CNT_W-1:0]     fifo_cnt;
  logic                 ovf;

  always #5 clk = ~clk;

  wb_collector #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX),
    .XLEN       (XLEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_rd_en (alu_rd_en),
    .alu_data  (alu_data),
    .su_valid  (su_valid),
    .su_ready  (su_ready),
    .su_data   (su_data),
    .wb_valid  (wb_valid),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_wdata  (wb_wdata),
    .wb_itag   (wb_itag),
    .fifo_cnt  (fifo_cnt),
    .ovf       (ovf)
  );

  typedef struct packed {
    logic    valid;
    wb_pkt_t pkt;
  } exp_t;

  // Scoreboard and reference-model state.
  exp_t    exp_q[$];
  wb_pkt_t m_fifo[$];
  int      m_starve;
  bit      m_ovf;
  wb_pkt_t m_last;
  logic    last_su_ready;
  int      su_seq;
  int      checks;
  int      errors;

  function automatic wb_pkt_t mk(input logic [63:0] d, input logic [4:0] r, input logic [4:0] t);
    wb_pkt_t p;
    p.data   = d;
    p.rd_idx = r;
    p.itag   = t;
    return p;
  endfunction

  function automatic wb_pkt_t next_su();
    su_seq++;
    return mk(64'h5000_0000_0000_0000 | 64'(su_seq), 5'(su_seq + 1), 5'(su_seq + 16));
  endfunction

  // One clock of traffic: drive, predict, check su_ready mid-cycle, then
  // compare the registered outputs against the scoreboard after the edge.
  task automatic cycle(input bit a_en, input wb_pkt_t a_p, input bit s_v,
                       input wb_pkt_t s_p, output bit granted);
    exp_t nxt;
    exp_t got;
    bit   empty;
    bit   g;
    bit   byp;
    alu_rd_en = a_en;
    alu_data  = a_p;
    su_valid  = s_v;
    su_data   = s_p;
    empty = (m_fifo.size() == 0);
    g     = s_v && (empty || m_starve >= STARVE_MAX);
    byp   = 1'b0;
    #2;
    last_su_ready = su_ready;
    checks++;
    if (su_ready !== g) begin
      errors++;
      $display("FAIL su_ready @%0t: got %b expected %b", $time, su_ready, g);
    end
    nxt.valid = 1'b1;
    nxt.pkt   = m_last;
    if (g)                  nxt.pkt = s_p;
    else if (!empty)        nxt.pkt = m_fifo.pop_front();
    else if (BYPASS && a_en) begin
      nxt.pkt = a_p;
      byp     = 1'b1;
    end else                nxt.valid = 1'b0;
    if (a_en && !byp) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(a_p);
      else                       m_ovf = 1'b1;
    end
    if (!s_v || g)                   m_starve = 0;
    else if (m_starve < STARVE_MAX)  m_starve++;
    m_last = nxt.pkt;
    exp_q.push_back(nxt);
    granted = g;
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    checks++;
    if (wb_valid !== got.valid || wb_we !== (got.valid && got.pkt.rd_idx != 5'd0) ||
        wb_rd !== got.pkt.rd_idx || wb_wdata !== got.pkt.data || wb_itag !== got.pkt.itag) begin
      errors++;
      $display("FAIL wb_out @%0t: got v=%b we=%b rd=%0d data=%h tag=%0d expected v=%b we=%b rd=%0d data=%h tag=%0d",
               $time, wb_valid, wb_we, wb_rd, wb_wdata, wb_itag, got.valid,
               got.valid && got.pkt.rd_idx != 5'd0, got.pkt.rd_idx, got.pkt.data, got.pkt.itag);
    end
    checks++;
    if (fifo_cnt !== CNT_W'(m_fifo.size())) begin
      errors++;
      $display("FAIL fifo_cnt @%0t: got %0d expected %0d", $time, fifo_cnt, m_fifo.size());
    end
    checks++;
    if (ovf !== m_ovf) begin
      errors++;
      $display("FAIL ovf @%0t: got %b expected %b", $time, ovf, m_ovf);
    end
  endtask

  // One reset cycle with traffic still being presented.
  task automatic do_reset(input bit s_v);
    rst_n     = 1'b0;
    alu_rd_en = 1'b1;
    alu_data  = mk(64'hBAD0_BAD0_BAD0_BAD0, 5'd17, 5'd9);
    su_valid  = s_v;
    su_data   = mk(64'hDEAD_0000_0000_0001, 5'd18, 5'd10);
    #2;
    checks++;
    if (su_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_su_ready: got %b expected 0", su_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_rd !== '0 || wb_wdata !== '0 ||
        wb_itag !== '0 || fifo_cnt !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b we=%b rd=%0d data=%h tag=%0d cnt=%0d ovf=%b expected all zero",
               wb_valid, wb_we, wb_rd, wb_wdata, wb_itag, fifo_cnt, ovf);
    end
    rst_n     = 1'b1;
    alu_rd_en = 1'b0;
    su_valid  = 1'b0;
    m_fifo.delete();
    exp_q.delete();
    m_starve = 0;
    m_ovf    = 1'b0;
    m_last   = '0;
  endtask

  task automatic idle(input int n);
    bit g;
    for (int i = 0; i < n; i++) cycle(1'b0, NO_PKT, 1'b0, NO_PKT, g);
  endtask

  task automatic test_reset();
    bit g;
    do_reset(1'b1);
    cycle(1'b0, NO_PKT, 1'b0, NO_PKT, g);
  endtask

  task automatic test_single_alu();
    bit g;
    int lat;
    cycle(1'b1, mk(64'h1234, 5'd5, 5'd3), 1'b0, NO_PKT, g);
    lat = 1;
    while (wb_valid !== 1'b1 && lat < 6) begin
      cycle(1'b0, NO_PKT, 1'b0, NO_PKT, g);
      lat++;
    end
    checks++;
    if (lat != EXP_LAT) begin
      errors++;
      $display("FAIL alu_latency: got %0d cycles expected %0d", lat, EXP_LAT);
    end
    checks++;
    if (wb_we !== 1'b1 || wb_rd !== 5'd5 || wb_wdata !== 64'h1234 || wb_itag !== 5'd3) begin
      errors++;
      $display("FAIL alu_single: got we=%b rd=%0d data=%h tag=%0d expected we=1 rd=5 data=1234 tag=3",
               wb_we, wb_rd, wb_wdata, wb_itag);
    end
    idle(2);
  endtask

  task automatic test_x0();
    bit g;
    int lat;
    cycle(1'b1, mk(64'hDEAD_BEEF, 5'd0, 5'd7), 1'b0, NO_PKT, g);
    lat = 1;
    while (wb_valid !== 1'b1 && lat < 6) begin
      cycle(1'b0, NO_PKT, 1'b0, NO_PKT, g);
      lat++;
    end
    checks++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_itag !== 5'd7) begin
      errors++;
      $display("FAIL x0_write: got v=%b we=%b tag=%0d expected v=1 we=0 tag=7", wb_valid, wb_we, wb_itag);
    end
    idle(2);
  endtask

  task automatic test_su_direct();
    bit g;
    cycle(1'b0, NO_PKT, 1'b1, mk(64'h5151, 5'd9, 5'd12), g);
    checks++;
    if (last_su_ready !== 1'b1) begin
      errors++;
      $display("FAIL su_direct_ready: got %b expected 1", last_su_ready);
    end
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd9 || wb_wdata !== 64'h5151 || wb_itag !== 5'd12) begin
      errors++;
      $display("FAIL su_direct: got v=%b rd=%0d data=%h tag=%0d expected v=1 rd=9 data=5151 tag=12",
               wb_valid, wb_rd, wb_wdata, wb_itag);
    end
    idle(1);
  endtask

  task automatic test_starve();
    bit      g;
    bit      saw;
    bit      pending;
    int      run;
    wb_pkt_t sp;
    cycle(1'b1, mk(64'hA0, 5'd1, 5'd0), 1'b0, NO_PKT, g);
    sp  = next_su();
    run = 0;
    saw = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b1, mk(64'hA0 + 64'(i), 5'(i + 1), 5'(i)), 1'b1, sp, g);
      if (last_su_ready === 1'b1) begin
        if (run == STARVE_MAX) saw = 1'b1;
        run = 0;
      end else begin
        run++;
      end
      if (g) sp = next_su();
    end
    checks++;
    if (saw !== 1'b1) begin
      errors++;
      $display("FAIL starve_grant: got %b expected 1 (grant after %0d denials)", saw, STARVE_MAX);
    end
    checks++;
    if (fifo_cnt < CNT_W'(2) || ovf !== 1'b0) begin
      errors++;
      $display("FAIL starve_fifo: got cnt=%0d ovf=%b expected cnt>=2 ovf=0", fifo_cnt, ovf);
    end
    pending = 1'b1;
    for (int k = 0; k < 12 && pending; k++) begin
      cycle(1'b0, NO_PKT, 1'b1, sp, g);
      if (g) pending = 1'b0;
    end
    checks++;
    if (pending) begin
      errors++;
      $display("FAIL starve_drain: su request still pending after 12 cycles expected accepted");
    end
    idle(DEPTH + 2);
  endtask

  task automatic test_overflow();
    bit      g;
    wb_pkt_t sp;
    sp = next_su();
    for (int i = 0; i < 40 && !m_ovf; i++) begin
      cycle(1'b1, mk(64'hB00 + 64'(i), 5'(i), 5'(i + 3)), 1'b1, sp, g);
      if (g) sp = next_su();
      if (m_fifo.size() == DEPTH && !m_ovf) begin
        checks++;
        if (ovf !== 1'b0 || fifo_cnt !== CNT_W'(DEPTH)) begin
          errors++;
          $display("FAIL full_no_drop: got cnt=%0d ovf=%b expected cnt=%0d ovf=0", fifo_cnt, ovf, DEPTH);
        end
      end
    end
    checks++;
    if (ovf !== 1'b1 || fifo_cnt !== CNT_W'(DEPTH)) begin
      errors++;
      $display("FAIL overflow: got cnt=%0d ovf=%b expected cnt=%0d ovf=1", fifo_cnt, ovf, DEPTH);
    end
    idle(DEPTH + 4);
    checks++;
    if (ovf !== 1'b1 || fifo_cnt !== '0) begin
      errors++;
      $display("FAIL ovf_sticky: got cnt=%0d ovf=%b expected cnt=0 ovf=1", fifo_cnt, ovf);
    end
  endtask

  task automatic test_reset_mid();
    bit      g;
    wb_pkt_t sp;
    sp = next_su();
    for (int i = 0; i < 40 && m_fifo.size() < 3; i++) begin
      cycle(1'b1, mk(64'hC00 + 64'(i), 5'(i + 2), 5'(i)), 1'b1, sp, g);
      if (g) sp = next_su();
    end
    checks++;
    if (fifo_cnt !== CNT_W'(3)) begin
      errors++;
      $display("FAIL mid_fill: got cnt=%0d expected 3", fifo_cnt);
    end
    do_reset(1'b1);
    idle(4);
    checks++;
    if (wb_valid !== 1'b0 || fifo_cnt !== '0) begin
      errors++;
      $display("FAIL mid_reset_stale: got v=%b cnt=%0d expected v=0 cnt=0", wb_valid, fifo_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit      g;
    bit      pend;
    wb_pkt_t sp;
    wb_pkt_t ap;
    pend = 1'b0;
    sp   = NO_PKT;
    for (int i = 0; i < 80; i++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        sp   = next_su();
      end
      ap = mk({$urandom(), $urandom()}, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      cycle(1'($urandom_range(0, 1)), ap, pend, sp, g);
      if (g) pend = 1'b0;
    end
    for (int k = 0; k < 12 && pend; k++) begin
      cycle(1'b0, NO_PKT, 1'b1, sp, g);
      if (g) pend = 1'b0;
    end
    checks++;
    if (pend) begin
      errors++;
      $display("FAIL b2b_drain: su request still pending after 12 cycles expected accepted");
    end
    idle(DEPTH + 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    su_seq        = 0;
    m_starve      = 0;
    m_ovf         = 1'b0;
    m_last        = '0;
    last_su_ready = 1'b0;
    rst_n         = 1'b0;
    alu_rd_en     = 1'b0;
    alu_data      = '0;
    su_valid      = 1'b0;
    su_data       = '0;
    test_reset();
    test_single_alu();
    test_x0();
    test_su_direct();
    test_starve();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
